gprf_dbg_access: RTL and testbench
==================================

# gprf_dbg_access

Debug-side initiator for the general-purpose register file (GPRF). When the OCD/JTAG front end has halted the core, this block turns byte-stream read and write commands into GPRF address, write-strobe and data cycles, with burst support. It sits between the OCD command decoder and the GPRF write/read port, and takes the port over from the core pipeline while a command is active.

## Interface
- `LEN_W`, default 5: width of the burst length field, which encodes count−1; bursts are 1..32 bytes.
- `cp2`  in  1  system clock; all state changes on rising edge.
- `ireset`  in  1  synchronous, active-low reset.
- `cp2en`  in  1  clock enable; the FSM advances and GPRF writes happen only when 1.
- `dbg_halted`  in  1  core halted; required for accepting and continuing commands.
- `cmd_valid` / `cmd_ready`  in/out  1  command handshake.
- `cmd_wr`  in  1  1 = write burst, 0 = read burst.
- `cmd_adr`  in  5  first register number, R0..R31.
- `cmd_len`  in  LEN_W  byte count minus 1.
- `wdata_valid` / `wdata_ready`  in/out  1  write-data handshake.
- `wdata`  in  8  write byte.
- `rdata_valid` / `rdata_ready`  out/in  1  read-data handshake.
- `rdata`  out  8  read byte, registered.
- `gprf_sel`  out  1  high while the block owns the GPRF port; drives the core/debug port mux.
- `gprf_adr`  out  5  GPRF address.
- `gprf_wr`  out  1  GPRF byte write strobe.
- `gprf_din`  out  8  GPRF write data.
- `gprf_dout`  in  8  GPRF combinational read data for `gprf_adr`.
- `done`  out  1  one-cycle pulse at command end.
- `err`  out  1  valid with `done`; 1 = aborted.

## Operation
- States: IDLE, WRITE, READ, RD_HOLD, DONE.
- IDLE
  - `cmd_ready` = `dbg_halted` & `cp2en`.
  - On accept: latch `cur_adr` ← `cmd_adr`, `remain` ← `cmd_len`, `mode` ← `cmd_wr`.
  - Next state is WRITE when `cmd_wr`=1, otherwise READ.
- WRITE
  - `wdata_ready` = `cp2en` & `dbg_halted`.
  - On handshake, combinationally in the same cycle: `gprf_wr`=1, `gprf_din`=`wdata`, `gprf_adr`=`cur_adr`.
  - Then `cur_adr`+1 (5-bit, R31 wraps to R0).
  - If `remain`=0, go to DONE; otherwise `remain`−1.
- READ
  - `gprf_adr`=`cur_adr`.
  - On a `cp2en` cycle: `rdata` ← `gprf_dout`, `rdata_valid` ← 1, go to RD_HOLD.
- RD_HOLD
  - `rdata`/`rdata_valid` are held stable until `rdata_ready`.
  - On handshake: `rdata_valid` ← 0.
  - If `remain`=0, go to DONE; otherwise `cur_adr`+1 (wrapping), `remain`−1, back to READ.
- DONE: `done`=1 for one cycle, `err` as latched; then IDLE.
- `gprf_sel`=1 in WRITE, READ and RD_HOLD; 0 in IDLE and DONE.
- `gprf_wr` is only ever 1 in WRITE, and is gated by `cp2en` & `dbg_halted`.
- Abort: `dbg_halted`=0 in WRITE, READ or RD_HOLD → clear `rdata_valid`, latch `err`=1, go to DONE. No further GPRF write occurs, including in the abort cycle.
- Outside an abort, `err` is cleared when a command is accepted.

## Timing
- Reset (`ireset`=0 at an edge): state IDLE.
  - All outputs 0: `cmd_ready`, `wdata_ready`, `rdata_valid`, `rdata`=0x00, `gprf_sel`, `gprf_adr`=0, `gprf_wr`, `gprf_din`=0, `done`, `err`.
  - Reset mid-burst drops the burst silently: no `done`.
- Write:
  - The first `wdata_ready` is in the cycle after the command is accepted.
  - Back-to-back bytes take one cycle each; the GPRF updates at the edge closing the handshake cycle.
- Read:
  - The first `rdata_valid` is 2 cycles after the command is accepted (READ cycle, then registered).
  - Each further byte costs 2 cycles (READ + RD_HOLD minimum).
- `done` asserts the cycle after the final data handshake. A new command can be accepted the cycle after `done`.
- `cp2en`=0 freezes the FSM; handshake readies are deasserted, while `rdata_valid` stays held.
- A 32-byte burst from any start address touches every register exactly once.

## Structure
- Package `gprf_dbg_pkg` holds:
  - the state enum `gprf_dbg_state_t`;
  - `GPRF_ADR_W`=5 and `GPRF_NUM`=32;
  - the mode constants `GPRF_DBG_RD`/`GPRF_DBG_WR`.
- Single module; no sub-module is needed.
- The address/remain counter is one always_ff next to the FSM.

## Test plan
- Write: `cmd_wr`=1, adr=5, len=2, wdata 0xA1,0xB2,0xC3 → `gprf_wr` pulses at R5,R6,R7 with those bytes; `done`=1, `err`=0.
- Read: adr=30, len=3, `gprf_dout` modelled as a 32×8 array preset to R30=0x11, R31=0x22, R0=0x33, R1=0x44 → `rdata` sequence 0x11,0x22,0x33,0x44; covers 31→0 wrap.
- Backpressure: during the read, `rdata_ready` is held low 5 cycles → `rdata` is stable and `gprf_adr` does not advance.
- Abort: `dbg_halted` drops after 2 of 4 write bytes → only 2 writes occur; `done`=1, `err`=1; `cmd_ready`=0 while halted=0.
- `cp2en` toggling 1/0 every cycle during a len=7 write → exactly 8 writes, each only in a `cp2en`=1 cycle.
- `ireset` low in RD_HOLD → next cycle all outputs 0, state IDLE, no `done`; a subsequent len=0 read of R0 returns correct data.

Source files
------------

// File: rtl/gprf_dbg_pkg.sv
// Shared types and constants for the debug-side GPRF access block.
package gprf_dbg_pkg;

  localparam int GPRF_ADR_W = 5;
  localparam int GPRF_NUM   = 32;

  // Burst direction as latched at command accept.
  localparam logic GPRF_DBG_RD = 1'b0;
  localparam logic GPRF_DBG_WR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RD_HOLD,
    ST_DONE
  } gprf_dbg_state_t;

  // Next register number; R31 rolls over to R0 so a full burst covers the file once.
  function automatic logic [GPRF_ADR_W-1:0] gprf_adr_next(input logic [GPRF_ADR_W-1:0] adr);
    return adr + GPRF_ADR_W'(1);
  endfunction

endpackage

// File: rtl/gprf_dbg_access.sv
// Debug-side GPRF initiator: turns OCD read/write burst commands into
// GPRF address / write-strobe / data cycles while the core is halted.
module gprf_dbg_access
  import gprf_dbg_pkg::*;
#(
  parameter int LEN_W = 5
) (
  input  logic                  cp2,
  input  logic                  ireset,
  input  logic                  cp2en,
  input  logic                  dbg_halted,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [GPRF_ADR_W-1:0] cmd_adr,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [7:0]            wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [7:0]            rdata,
  output logic                  gprf_sel,
  output logic [GPRF_ADR_W-1:0] gprf_adr,
  output logic                  gprf_wr,
  output logic [7:0]            gprf_din,
  input  logic [7:0]            gprf_dout,
  output logic                  done,
  output logic                  err
);

  gprf_dbg_state_t       state;
  logic [GPRF_ADR_W-1:0] cur_adr;
  logic [LEN_W-1:0]      remain;
  logic                  mode;
  logic                  err_q;

  logic live;
  logic cmd_accept;
  logic wr_hs;
  logic rd_hs;
  logic abort;
  logic last;

  // A cycle only does useful work when clock-enabled and the core is halted.
  assign live = cp2en & dbg_halted;

  // Commands are refused while reset is held so nothing is accepted and then lost.
  assign cmd_ready  = (state == ST_IDLE) & live & ireset;
  assign cmd_accept = cmd_valid & cmd_ready;

  assign wdata_ready = (state == ST_WRITE) & live;
  assign wr_hs       = wdata_ready & wdata_valid;
  assign rd_hs       = (state == ST_RD_HOLD) & rdata_valid & rdata_ready & live;

  // The port is owned for the whole burst; losing halt while owning it aborts.
  assign gprf_sel = (state == ST_WRITE) | (state == ST_READ) | (state == ST_RD_HOLD);
  assign abort    = gprf_sel & ~dbg_halted;
  assign last     = (remain == '0);

  // Write strobe and data are combinational so the GPRF captures the byte at
  // the edge that closes the write handshake; halt loss blocks it via live.
  assign gprf_wr  = wr_hs & (mode == GPRF_DBG_WR);
  assign gprf_din = gprf_wr ? wdata : 8'h00;
  assign gprf_adr = gprf_sel ? cur_adr : '0;

  assign done = (state == ST_DONE);
  assign err  = done & err_q;

  // Main FSM with registered read data, read valid and abort flag.
  always_ff @(posedge cp2) begin
    // NOTE: every register here is assigned with <= so all of them update
    // together from the values seen before the edge.
    if (!ireset) begin
      state       <= ST_IDLE;
      rdata       <= 8'h00;
      rdata_valid <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_accept) begin
            err_q <= 1'b0;
            state <= (cmd_wr == GPRF_DBG_WR) ? ST_WRITE : ST_READ;
          end
        end

        ST_WRITE: begin
          if (abort) begin
            err_q <= 1'b1;
            state <= ST_DONE;
          end else if (wr_hs && last) begin
            state <= ST_DONE;
          end
        end

        ST_READ: begin
          if (abort) begin
            rdata_valid <= 1'b0;
            err_q       <= 1'b1;
            state       <= ST_DONE;
          end else if (cp2en) begin
            rdata       <= gprf_dout;
            rdata_valid <= 1'b1;
            state       <= ST_RD_HOLD;
          end
        end

        ST_RD_HOLD: begin
          if (abort) begin
            rdata_valid <= 1'b0;
            err_q       <= 1'b1;
            state       <= ST_DONE;
          end else if (rd_hs) begin
            rdata_valid <= 1'b0;
            state       <= last ? ST_DONE : ST_READ;
          end
        end

        // done is a single-cycle pulse even if the clock enable is low.
        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Burst address / remaining-count bookkeeping alongside the FSM.
  always_ff @(posedge cp2) begin
    if (!ireset) begin
      cur_adr <= '0;
      remain  <= '0;
      mode    <= GPRF_DBG_RD;
    end else if (cmd_accept) begin
      cur_adr <= cmd_adr;
      remain  <= cmd_len;
      mode    <= cmd_wr;
    end else if (wr_hs) begin
      cur_adr <= gprf_adr_next(cur_adr);
      if (!last) remain <= remain - LEN_W'(1);
    end else if (rd_hs && !last) begin
      cur_adr <= gprf_adr_next(cur_adr);
      remain  <= remain - LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_gprf_dbg_access.sv
// Self-checking bench for gprf_dbg_access: transaction-level model plus
// directed literal checks, then randomized bursts with stalls and aborts.
module tb_gprf_dbg_access;

  localparam int LEN_W = 5;

  logic             cp2 = 1'b0;
  logic             ireset = 1'b0;
  logic             cp2en = 1'b1;
  logic             dbg_halted = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_wr = 1'b0;
  logic [4:0]       cmd_adr = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             wdata_valid = 1'b0;
  logic             wdata_ready;
  logic [7:0]       wdata = '0;
  logic             rdata_valid;
  logic             rdata_ready = 1'b0;
  logic [7:0]       rdata;
  logic             gprf_sel;
  logic [4:0]       gprf_adr;
  logic             gprf_wr;
  logic [7:0]       gprf_din;
  logic [7:0]       gprf_dout;
  logic             done;
  logic             err;

  gprf_dbg_access #(.LEN_W(LEN_W)) dut (
    .cp2(cp2), .ireset(ireset), .cp2en(cp2en), .dbg_halted(dbg_halted),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .gprf_sel(gprf_sel), .gprf_adr(gprf_adr), .gprf_wr(gprf_wr),
    .gprf_din(gprf_din), .gprf_dout(gprf_dout), .done(done), .err(err)
  );

  initial forever #5 cp2 = ~cp2;

  // GPRF environment: 32 x 8 file, combinational read, preset port for the bench.
  logic [7:0] gprf_mem [32];
  logic       pre_en = 1'b0;
  logic [4:0] pre_adr = '0;
  logic [7:0] pre_val = '0;

  always @(posedge cp2) begin
    if (pre_en) gprf_mem[pre_adr] <= pre_val;
    else if (gprf_wr) gprf_mem[gprf_adr] <= gprf_din;
  end
  assign gprf_dout = gprf_mem[gprf_adr];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // cp2en pattern: 0 = always on, 1 = toggle every cycle, 2 = random.
  int cp_mode = 0;
  initial forever begin
    @(posedge cp2); #1;
    case (cp_mode)
      0:       cp2en = 1'b1;
      1:       cp2en = ~cp2en;
      default: cp2en = 1'($urandom_range(1, 0));
    endcase
  end

  // Bytes the driver will send for the next write command.
  logic [7:0] wbytes [$];
  // Bytes collected by the read driver.
  logic [7:0] rq [$];

  // ---------------- transaction-level model and per-cycle compare ----------
  bit         m_busy = 0;
  bit         m_wr = 0;
  bit         m_done_now = 0;
  bit         m_err = 0;
  bit         hold_prev = 0;
  logic [4:0] m_adr = '0;
  int         m_left = 0;
  logic [7:0] m_wq [$];
  logic [7:0] m_rq [$];
  logic [7:0] prev_rdata = '0;
  int         done_cnt = 0;
  int         wr_cnt = 0;
  bit         last_err = 0;

  initial begin : compare
    forever begin
      @(negedge cp2);
      if (!ireset) begin
        m_busy = 0; m_done_now = 0; hold_prev = 0;
        m_wq.delete(); m_rq.delete();
      end else begin
        bit live, exp_rdy, exp_wr, rd_hs, nxt_done;
        live    = cp2en && dbg_halted;
        exp_rdy = !m_busy && !m_done_now && live;
        exp_wr  = m_busy && m_wr && live && wdata_valid;
        rd_hs   = m_busy && !m_wr && live && rdata_valid && rdata_ready;

        check("cmd_ready", cmd_ready, exp_rdy);
        check("wdata_ready", wdata_ready, m_busy && m_wr && live);
        check("gprf_sel", gprf_sel, m_busy);
        check("gprf_adr", gprf_adr, m_busy ? m_adr : 5'd0);
        check("gprf_wr", gprf_wr, exp_wr);
        check("done", done, m_done_now);
        if (done) begin
          done_cnt++;
          last_err = err;
          check("err", err, m_err);
        end
        if (!m_busy || m_wr) check("rdata_valid_idle", rdata_valid, 1'b0);
        if (hold_prev) begin
          check("rdata_valid_hold", rdata_valid, 1'b1);
          check("rdata_hold", rdata, prev_rdata);
        end
        if (exp_wr && gprf_wr) begin
          wr_cnt++;
          check("write_expected", m_wq.size() > 0, 1'b1);
          if (m_wq.size() > 0) check("gprf_din", gprf_din, m_wq[0]);
        end
        if (rd_hs) begin
          check("read_expected", m_rq.size() > 0, 1'b1);
          if (m_rq.size() > 0) check("rdata", rdata, m_rq[0]);
        end
        hold_prev  = rdata_valid && !rd_hs && !(m_busy && !dbg_halted);
        prev_rdata = rdata;

        // Advance the model to the next cycle.
        nxt_done = 0;
        if (m_busy && !dbg_halted) begin
          m_busy = 0; nxt_done = 1; m_err = 1;
          m_wq.delete(); m_rq.delete();
        end else if (exp_wr) begin
          if (m_wq.size() > 0) void'(m_wq.pop_front());
          m_adr++;
          m_left--;
          if (m_left == 0) begin m_busy = 0; nxt_done = 1; m_err = 0; end
        end else if (rd_hs) begin
          if (m_rq.size() > 0) void'(m_rq.pop_front());
          m_left--;
          if (m_left == 0) begin m_busy = 0; nxt_done = 1; m_err = 0; end
          else m_adr++;
        end
        if (cmd_valid && exp_rdy) begin
          m_busy = 1; m_wr = cmd_wr; m_adr = cmd_adr;
          m_left = int'(cmd_len) + 1; m_err = 0;
          m_wq.delete(); m_rq.delete();
          if (cmd_wr) m_wq = wbytes;
          else for (int i = 0; i < m_left; i++) m_rq.push_back(gprf_mem[5'(int'(cmd_adr) + i)]);
        end
        m_done_now = nxt_done;
      end
    end
  end

  // ---------------- drivers ------------------------------------------------
  task automatic preset(input logic [4:0] adr, input logic [7:0] val);
    pre_adr = adr; pre_val = val; pre_en = 1'b1;
    @(posedge cp2); #1;
    pre_en = 1'b0;
  endtask

  task automatic send_cmd(input logic wr, input logic [4:0] adr, input int len);
    bit ok = 0;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_adr = adr; cmd_len = LEN_W'(len);
    for (int k = 0; k < 200; k++) begin
      @(negedge cp2);
      if (cmd_ready) begin ok = 1; break; end
      @(posedge cp2); #1;
    end
    if (!ok) check("cmd_accept_timeout", ok, 1'b1);
    @(posedge cp2); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge cp2);
      if (done) begin seen = 1; break; end
      @(posedge cp2); #1;
    end
    if (!seen) check(name, seen, 1'b1);
  endtask

  // Drop halt mid-burst, wait out the aborted done, confirm no accept while unhalted.
  task automatic abort_seq();
    dbg_halted = 1'b0; wdata_valid = 1'b0; rdata_ready = 1'b0;
    wait_done("abort_done_timeout");
    @(posedge cp2); #1;
    @(negedge cp2);
    check("abort_cmd_ready", cmd_ready, 1'b0);
    @(posedge cp2); #1;
    dbg_halted = 1'b1;
  endtask

  task automatic do_write(input int n, input int abort_at);
    bit ok;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin abort_seq(); return; end
      wdata_valid = 1'b1; wdata = wbytes[i];
      ok = 0;
      for (int k = 0; k < 200; k++) begin
        @(negedge cp2);
        if (wdata_ready) begin ok = 1; break; end
        @(posedge cp2); #1;
      end
      if (!ok) begin check("wdata_hs_timeout", ok, 1'b1); wdata_valid = 1'b0; return; end
      @(posedge cp2); #1;
    end
    wdata_valid = 1'b0;
    wait_done("write_done_timeout");
    @(posedge cp2); #1;
  endtask

  task automatic do_read(input int n, input int abort_at, input int stall_idx,
                         input int stall_n, input int max_stall);
    bit ok;
    int stall;
    rq.delete();
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin abort_seq(); return; end
      ok = 0;
      for (int k = 0; k < 200; k++) begin
        @(negedge cp2);
        if (rdata_valid) begin ok = 1; break; end
        @(posedge cp2); #1;
      end
      if (!ok) begin check("rdata_valid_timeout", ok, 1'b1); return; end
      stall = (i == stall_idx) ? stall_n : $urandom_range(max_stall, 0);
      repeat (stall) @(posedge cp2);
      @(posedge cp2); #1;
      rdata_ready = 1'b1;
      ok = 0;
      for (int k = 0; k < 200; k++) begin
        @(negedge cp2);
        if (rdata_valid && cp2en && dbg_halted) begin rq.push_back(rdata); ok = 1; break; end
        @(posedge cp2); #1;
      end
      if (!ok) begin check("rdata_hs_timeout", ok, 1'b1); rdata_ready = 1'b0; return; end
      @(posedge cp2); #1;
      rdata_ready = 1'b0;
    end
    wait_done("read_done_timeout");
    @(posedge cp2); #1;
  endtask

  task automatic check_zero(input string p);
    check({p, "_cmd_ready"}, cmd_ready, 1'b0);
    check({p, "_wdata_ready"}, wdata_ready, 1'b0);
    check({p, "_rdata_valid"}, rdata_valid, 1'b0);
    check({p, "_rdata"}, rdata, 8'h00);
    check({p, "_gprf_sel"}, gprf_sel, 1'b0);
    check({p, "_gprf_adr"}, gprf_adr, 5'd0);
    check({p, "_gprf_wr"}, gprf_wr, 1'b0);
    check({p, "_gprf_din"}, gprf_din, 8'h00);
    check({p, "_done"}, done, 1'b0);
    check({p, "_err"}, err, 1'b0);
  endtask

  // ---------------- stimulus -----------------------------------------------
  logic [7:0] exp_rd [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin : main
    int d0, w0;
    // Reset state with halt and enable both high: outputs must still be quiet.
    repeat (3) @(posedge cp2);
    @(negedge cp2);
    check_zero("rst");
    @(posedge cp2); #1;
    ireset = 1'b1;

    // Write burst R5..R7.
    wbytes = '{8'hA1, 8'hB2, 8'hC3};
    d0 = done_cnt;
    send_cmd(1'b1, 5'd5, 2);
    @(negedge cp2);
    check("wr_first_ready", wdata_ready, 1'b1);
    @(posedge cp2); #1;
    do_write(3, -1);
    check("wr_r5", gprf_mem[5], 8'hA1);
    check("wr_r6", gprf_mem[6], 8'hB2);
    check("wr_r7", gprf_mem[7], 8'hC3);
    check("wr_done_cnt", done_cnt - d0, 1);
    check("wr_err", last_err, 1'b0);

    // Read across the R31 -> R0 wrap with a 5-cycle stall on the second byte.
    preset(5'd30, 8'h11); preset(5'd31, 8'h22); preset(5'd0, 8'h33); preset(5'd1, 8'h44);
    send_cmd(1'b0, 5'd30, 3);
    @(negedge cp2);
    check("rd_lat_c1", rdata_valid, 1'b0);
    @(posedge cp2); #1;
    @(negedge cp2);
    check("rd_lat_c2", rdata_valid, 1'b1);
    @(posedge cp2); #1;
    do_read(4, -1, 1, 5, 0);
    check("rd_count", rq.size(), 4);
    for (int i = 0; i < 4 && i < rq.size(); i++) check($sformatf("rd_byte%0d", i), rq[i], exp_rd[i]);

    // Abort after two of four write bytes.
    for (int i = 0; i < 4; i++) preset(5'(9 + i), 8'(8'hE0 + i));
    wbytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    d0 = done_cnt;
    send_cmd(1'b1, 5'd9, 3);
    do_write(4, 2);
    check("ab_r9", gprf_mem[9], 8'h01);
    check("ab_r10", gprf_mem[10], 8'h02);
    check("ab_r11", gprf_mem[11], 8'hE2);
    check("ab_r12", gprf_mem[12], 8'hE3);
    check("ab_done_cnt", done_cnt - d0, 1);
    check("ab_err", last_err, 1'b1);

    // cp2en toggling during an 8-byte write.
    wbytes.delete();
    for (int i = 0; i < 8; i++) wbytes.push_back(8'(8'h60 + i));
    w0 = wr_cnt;
    cp_mode = 1;
    send_cmd(1'b1, 5'd20, 7);
    do_write(8, -1);
    cp_mode = 0;
    check("tog_wr_cnt", wr_cnt - w0, 8);
    for (int i = 0; i < 8; i++) check($sformatf("tog_r%0d", 20 + i), gprf_mem[20 + i], 8'(8'h60 + i));

    // 32-byte burst from R17 touches every register once.
    wbytes.delete();
    for (int i = 0; i < 32; i++) wbytes.push_back(8'(i) ^ 8'h5A);
    send_cmd(1'b1, 5'd17, 31);
    do_write(32, -1);
    for (int i = 0; i < 32; i++)
      check($sformatf("full_r%0d", (17 + i) % 32), gprf_mem[(17 + i) % 32], 8'(i) ^ 8'h5A);

    // Reset while holding read data: everything quiet, no done afterwards.
    preset(5'd3, 8'h7E);
    send_cmd(1'b0, 5'd3, 2);
    begin
      bit ok = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge cp2);
        if (rdata_valid) begin ok = 1; break; end
        @(posedge cp2); #1;
      end
      check("rst_mid_reached_hold", ok, 1'b1);
    end
    @(posedge cp2); #1;
    ireset = 1'b0;
    @(posedge cp2); #1;
    @(negedge cp2);
    check_zero("rst_mid");
    d0 = done_cnt;
    @(posedge cp2); #1;
    ireset = 1'b1;
    repeat (4) @(posedge cp2);
    #1;
    check("rst_mid_no_done", done_cnt - d0, 0);
    preset(5'd0, 8'h9C);
    send_cmd(1'b0, 5'd0, 0);
    do_read(1, -1, -1, 0, 0);
    check("rst_post_count", rq.size(), 1);
    if (rq.size() > 0) check("rst_post_byte", rq[0], 8'h9C);

    // Randomized bursts with random enable, stalls and occasional aborts.
    for (int t = 0; t < 40; t++) begin
      logic       wr;
      logic [4:0] adr;
      int         len, abort_at;
      cp_mode  = 2 * $urandom_range(1, 0);
      wr       = 1'($urandom_range(1, 0));
      adr      = 5'($urandom_range(31, 0));
      len      = $urandom_range(31, 0);
      abort_at = ($urandom_range(5, 0) == 0) ? $urandom_range(len, 0) : -1;
      wbytes.delete();
      for (int i = 0; i <= len; i++) wbytes.push_back(8'($urandom_range(255, 0)));
      send_cmd(wr, adr, len);
      if (wr) do_write(len + 1, abort_at);
      else do_read(len + 1, abort_at, -1, 0, 2);
    end
    cp_mode = 0;
    repeat (3) @(posedge cp2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule
